image_saturation_adjust_pipe: RTL

Parametrised successor of the saturation stage: blends each RGB pixel with its luma, `out = P + k*(P - Y)`, with channel width set by parameter.
Adds frame-synchronous shadowing of the control inputs, a bypass mode and exact identity at zero adjustment.
Sits in the video pipeline between colour-space/ISP stages and the display/encoder path, on a valid-qualified pixel stream with vs/hs side-band.

---
 rtl/image_saturation_adjust_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/image_saturation_adjust_pipe.sv
// Four-stage saturation blend out = P + k*(P - Y), with frame-synchronous control shadowing and bypass.
// Optional per-frame clip counter is built when IMAGE_SATURATION_CLIP_CNT_EN is defined.
module image_saturation_adjust_pipe #(
   parameter int DW     = 8,
   parameter bit VS_POL = 1'b1,
   parameter int CNT_W  = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DW+1:0]     adjust_val,
   input  logic              bypass,
   input  logic              vs_in,
   input  logic              hs_in,
   input  logic              valid_i,
   input  logic [3*DW-1:0]   img_data_i,
   output logic              vs_out,
   output logic              hs_out,
   output logic              valid_o,
   output logic [3*DW-1:0]   img_data_o,
   output logic [CNT_W-1:0]  clip_cnt
);
   localparam int STAGES = 4;
   localparam int KW     = DW + 2;
   localparam int YW     = DW + 10;
   localparam int SW     = 3*DW + 3;
   localparam logic signed [KW-1:0] K_MAX   = KW'(2**DW);
   localparam logic signed [KW-1:0] K_MIN   = -K_MAX;
   localparam logic signed [SW-1:0] PIX_MAX = SW'(2**DW - 1);

   typedef logic [2:0][DW-1:0] pix_t;   // [2]=R, [1]=G, [0]=B

   logic                 vs_d_q, frame_start;
   logic signed [KW-1:0] adj_clamped, k_act_q, k_in;
   logic                 byp_act_q, byp_in;

   logic [STAGES:1]      vld_pipe_q, vs_pipe_q, hs_pipe_q;
   pix_t                 pix_in, pix1_q, pix2_q, pix3_q, out_q, out_d;
   logic [2:0][YW-1:0]   lp1_q, lp1_d;
   logic [YW-1:0]        ysum;
   logic [DW-1:0]        y2_q, y2_d;
   logic signed [KW-1:0] k1_q, k2_q;
   logic                 byp1_q, byp2_q, byp3_q;
   logic signed [SW-1:0] k_ext, gain;
   logic [2:0][SW-1:0]   prod3_q, prod3_d, sh4;
   logic [SW-1:0]        yk3_q, yk3_d;

   assign frame_start = (vs_in == VS_POL) && (vs_d_q != VS_POL);

   always_comb begin
      adj_clamped = $signed(adjust_val);
      if ($signed(adjust_val) > K_MAX)      adj_clamped = K_MAX;
      else if ($signed(adjust_val) < K_MIN) adj_clamped = K_MIN;
   end

   // The pixel entering on the frame-start cycle already uses the new controls.
   assign k_in   = frame_start ? adj_clamped : k_act_q;
   assign byp_in = frame_start ? bypass      : byp_act_q;

   assign pix_in = img_data_i;

   // Stage 1: luma partial products (weights sum to 1024, so white cannot overflow).
   always_comb begin
      lp1_d[2] = YW'(pix_in[2]) * YW'(306);
      lp1_d[1] = YW'(pix_in[1]) * YW'(601);
      lp1_d[0] = YW'(pix_in[0]) * YW'(117);
   end

   assign ysum = lp1_q[0] + lp1_q[1] + lp1_q[2];
   assign y2_d = DW'(ysum >> 10);

   // Stage 3: S = P*(2^DW + k) - Y*k, split into two registered products.
   always_comb begin
      k_ext = {{(SW-KW){k2_q[KW-1]}}, k2_q};
      gain  = SW'(2**DW) + k_ext;
      for (int c = 0; c < 3; c++)
         prod3_d[c] = $signed({{(SW-DW){1'b0}}, pix2_q[c]}) * gain;
      yk3_d = $signed({{(SW-DW){1'b0}}, y2_q}) * k_ext;
   end

   // Stage 4: floor shift and clip; bypass selects the untouched pixel.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         sh4[c] = ($signed(prod3_q[c]) - $signed(yk3_q)) >>> DW;
         if ($signed(sh4[c]) < 0)            out_d[c] = '0;
         else if ($signed(sh4[c]) > PIX_MAX) out_d[c] = '1;
         else                                out_d[c] = sh4[c][DW-1:0];
         if (byp3_q) out_d[c] = pix3_q[c];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_d_q     <= 1'b0;
         k_act_q    <= '0;
         byp_act_q  <= 1'b0;
         vld_pipe_q <= '0;
         vs_pipe_q  <= '0;
         hs_pipe_q  <= '0;
         pix1_q     <= '0;
         lp1_q      <= '0;
         k1_q       <= '0;
         byp1_q     <= 1'b0;
         pix2_q     <= '0;
         y2_q       <= '0;
         k2_q       <= '0;
         byp2_q     <= 1'b0;
         pix3_q     <= '0;
         prod3_q    <= '0;
         yk3_q      <= '0;
         byp3_q     <= 1'b0;
         out_q      <= '0;
      end else begin
         vs_d_q <= vs_in;
         if (frame_start) begin
            k_act_q   <= adj_clamped;
            byp_act_q <= bypass;
         end
         vld_pipe_q <= {vld_pipe_q[STAGES-1:1], valid_i};
         vs_pipe_q  <= {vs_pipe_q[STAGES-1:1], vs_in};
         hs_pipe_q  <= {hs_pipe_q[STAGES-1:1], hs_in};
         pix1_q     <= pix_in;
         lp1_q      <= lp1_d;
         k1_q       <= k_in;
         byp1_q     <= byp_in;
         pix2_q     <= pix1_q;
         y2_q       <= y2_d;
         k2_q       <= k1_q;
         byp2_q     <= byp1_q;
         pix3_q     <= pix2_q;
         prod3_q    <= prod3_d;
         yk3_q      <= yk3_d;
         byp3_q     <= byp2_q;
         out_q      <= out_d;
      end
   end

   assign valid_o    = vld_pipe_q[STAGES];
   assign vs_out     = vs_pipe_q[STAGES];
   assign hs_out     = hs_pipe_q[STAGES];
   assign img_data_o = out_q;

`ifdef IMAGE_SATURATION_CLIP_CNT_EN
   logic [CNT_W-1:0] cnt_q, clip_cnt_q;
   logic             clip_evt, fs_out;

   always_comb begin
      clip_evt = 1'b0;
      for (int c = 0; c < 3; c++)
         if ($signed(sh4[c]) < 0 || $signed(sh4[c]) > PIX_MAX) clip_evt = 1'b1;
      clip_evt = clip_evt && vld_pipe_q[STAGES-1] && !byp3_q;
   end

   // Output-side frame start: the edge where vs_out is about to enter VS_POL.
   assign fs_out = (vs_pipe_q[STAGES-1] == VS_POL) && (vs_pipe_q[STAGES] != VS_POL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         clip_cnt_q <= '0;
      end else if (fs_out) begin
         clip_cnt_q <= cnt_q;
         cnt_q      <= CNT_W'(clip_evt);
      end else if (clip_evt && cnt_q != '1) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign clip_cnt = clip_cnt_q;
`else
   assign clip_cnt = '0;
`endif

endmodule
